util_fifo_rd_sched: RTL and testbench

Round-robin read scheduler that shares one Avalon-ST transmit interface between NUM_CH upstream sample FIFOs in the harden_tx path. It grants a channel only when that channel holds a full burst. It then issues the FIFO read enables and retimes the returned words through a small credit-controlled skid buffer. Output packets carry SOP/EOP and a channel tag.

---
 rtl/util_fifo_rd_sched_if.sv | 43 ++++
 rtl/util_fifo_rd_sched.sv | 193 +++++++++++++++++++
 tb/tb_util_fifo_rd_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/util_fifo_rd_sched_if.sv
// FIFO-side and Avalon-ST-side signals of the round-robin FIFO read scheduler.
// The scheduler takes the master modport; the FIFOs and Avalon sink take the slave modport.
interface util_fifo_rd_sched_if #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEVEL_W = 8
) ();

    logic [NUM_CH*LEVEL_W-1:0] ch_level;
    logic [NUM_CH-1:0]         ch_rd_en;
    logic [NUM_CH*DATA_W-1:0]  ch_rd_data;
    logic                      avl_ready;
    logic                      avl_valid;
    logic [DATA_W-1:0]         avl_data;
    logic                      avl_sop;
    logic                      avl_eop;
    logic [2:0]                avl_channel;

    modport master (
        input  ch_level,
        input  ch_rd_data,
        input  avl_ready,
        output ch_rd_en,
        output avl_valid,
        output avl_data,
        output avl_sop,
        output avl_eop,
        output avl_channel
    );

    modport slave (
        output ch_level,
        output ch_rd_data,
        output avl_ready,
        input  ch_rd_en,
        input  avl_valid,
        input  avl_data,
        input  avl_sop,
        input  avl_eop,
        input  avl_channel
    );

endinterface

// File: rtl/util_fifo_rd_sched.sv
// Round-robin burst read scheduler: grants one FIFO channel per full burst, issues read enables
// under credit control and retimes the returned words through a skid FIFO onto Avalon-ST.
module util_fifo_rd_sched #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LEVEL_W    = 8,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    util_fifo_rd_sched_if.master bus
);

    localparam int unsigned SkidDepth = RD_LATENCY + 2;
    localparam int unsigned ChW       = $clog2(NUM_CH);
    localparam int unsigned PtrW      = $clog2(SkidDepth);
    localparam int unsigned CntW      = $clog2(SkidDepth + 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    typedef struct packed {
        logic [ChW-1:0] ch;
        logic           sop;
        logic           eop;
    } tag_t;

    state_e             state_q, state_d;
    logic [ChW-1:0]     grant_q, grant_d;
    logic [ChW-1:0]     last_grant_q, last_grant_d;
    logic [LEVEL_W-1:0] word_cnt_q, word_cnt_d;
    logic [CntW-1:0]    inflight_q, inflight_d;
    logic [CntW-1:0]    skid_cnt_q, skid_cnt_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic               pipe_vld_q [RD_LATENCY];
    logic               pipe_vld_d [RD_LATENCY];
    tag_t               pipe_tag_q [RD_LATENCY];
    tag_t               pipe_tag_d [RD_LATENCY];
    logic [DATA_W-1:0]  skid_data_q [SkidDepth];
    logic [DATA_W-1:0]  skid_data_d [SkidDepth];
    tag_t               skid_tag_q [SkidDepth];
    tag_t               skid_tag_d [SkidDepth];

    logic [NUM_CH-1:0]  eligible;
    logic               pick_vld;
    logic [ChW-1:0]     pick_ch;
    logic               credit_ok;
    logic               rd_fire;
    logic               push;
    tag_t               push_tag;
    logic [DATA_W-1:0]  push_data;
    logic               skid_vld;
    logic               pop;
    tag_t               head_tag;

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            eligible[i] = bus.ch_level[i*LEVEL_W +: LEVEL_W] >= LEVEL_W'(BURST_LEN);
        end
    end

    // Walk downward so the last hit is the nearest channel above last_grant_q.
    always_comb begin
        pick_vld = 1'b0;
        pick_ch  = '0;
        for (int k = int'(NUM_CH); k >= 1; k--) begin
            if (eligible[(int'(last_grant_q) + k) % int'(NUM_CH)]) begin
                pick_vld = 1'b1;
                pick_ch  = ChW'((int'(last_grant_q) + k) % int'(NUM_CH));
            end
        end
    end

    assign credit_ok = ({1'b0, skid_cnt_q} + {1'b0, inflight_q}) < (CntW + 1)'(SkidDepth);
    assign rd_fire   = (state_q == StBurst) && credit_ok;
    assign bus.ch_rd_en = rd_fire ? (NUM_CH'(1) << grant_q) : '0;

    assign push      = pipe_vld_q[RD_LATENCY-1];
    assign push_tag  = pipe_tag_q[RD_LATENCY-1];
    assign push_data = bus.ch_rd_data[int'(push_tag.ch) * int'(DATA_W) +: DATA_W];

    assign skid_vld  = (skid_cnt_q != '0);
    assign pop       = skid_vld && bus.avl_ready;
    assign head_tag  = skid_tag_q[rd_ptr_q];

    assign bus.avl_valid   = skid_vld;
    assign bus.avl_data    = skid_vld ? skid_data_q[rd_ptr_q] : '0;
    assign bus.avl_sop     = skid_vld && head_tag.sop;
    assign bus.avl_eop     = skid_vld && head_tag.eop;
    assign bus.avl_channel = skid_vld ? 3'(head_tag.ch) : 3'd0;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        word_cnt_d   = word_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (enable && pick_vld) begin
                    grant_d      = pick_ch;
                    last_grant_d = pick_ch;
                    word_cnt_d   = '0;
                    state_d      = StBurst;
                end
            end
            StBurst: begin
                if (rd_fire) begin
                    if (word_cnt_q == LEVEL_W'(BURST_LEN - 1)) begin
                        state_d = StIdle;
                    end else begin
                        word_cnt_d = word_cnt_q + LEVEL_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pipe_vld_d[0] = rd_fire;
        pipe_tag_d[0] = '{ch:  grant_q,
                          sop: (word_cnt_q == '0),
                          eop: (word_cnt_q == LEVEL_W'(BURST_LEN - 1))};
        for (int j = 1; j < int'(RD_LATENCY); j++) begin
            pipe_vld_d[j] = pipe_vld_q[j-1];
            pipe_tag_d[j] = pipe_tag_q[j-1];
        end
    end

    always_comb begin
        inflight_d  = inflight_q;
        skid_cnt_d  = skid_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        unique case ({rd_fire, push})
            2'b10:   inflight_d = inflight_q + CntW'(1);
            2'b01:   inflight_d = inflight_q - CntW'(1);
            default: inflight_d = inflight_q;
        endcase
        unique case ({push, pop})
            2'b10:   skid_cnt_d = skid_cnt_q + CntW'(1);
            2'b01:   skid_cnt_d = skid_cnt_q - CntW'(1);
            default: skid_cnt_d = skid_cnt_q;
        endcase
        if (push) begin
            skid_data_d[wr_ptr_q] = push_data;
            skid_tag_d[wr_ptr_q]  = push_tag;
            wr_ptr_d = (wr_ptr_q == PtrW'(SkidDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(SkidDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= ChW'(NUM_CH - 1);
            word_cnt_q   <= '0;
            inflight_q   <= '0;
            skid_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int j = 0; j < int'(RD_LATENCY); j++) begin
                pipe_vld_q[j] <= 1'b0;
                pipe_tag_q[j] <= '0;
            end
            for (int j = 0; j < int'(SkidDepth); j++) begin
                skid_data_q[j] <= '0;
                skid_tag_q[j]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            word_cnt_q   <= word_cnt_d;
            inflight_q   <= inflight_d;
            skid_cnt_q   <= skid_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_tag_q   <= pipe_tag_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

endmodule

// File: tb/tb_util_fifo_rd_sched.sv
// Bench for util_fifo_rd_sched: emulated upstream FIFOs with read latency, and a packet-level
// round-robin model that predicts the output word stream.
module tb_util_fifo_rd_sched;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LEVEL_W    = 8;
    localparam int unsigned BURST_LEN  = 16;
    localparam int unsigned RD_LATENCY = 2;
    localparam int unsigned SKID_DEPTH = RD_LATENCY + 2;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    util_fifo_rd_sched_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .LEVEL_W(LEVEL_W)) bus ();

    util_fifo_rd_sched #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .LEVEL_W   (LEVEL_W),
        .BURST_LEN (BURST_LEN),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(enable),
        .bus   (bus)
    );

    typedef logic [DATA_W-1:0] word_q_t[$];
    typedef struct {
        logic [2:0]        ch;
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } exp_t;
    typedef struct {
        bit                vld;
        int unsigned       ch;
        logic [DATA_W-1:0] data;
    } rd_t;

    word_q_t fq [NUM_CH];  // contents of the emulated upstream FIFOs
    word_q_t mq [NUM_CH];  // model copy, consumed by packet prediction
    exp_t    exp_q[$];
    rd_t     rd_pipe [RD_LATENCY+1];
    int      pkt_ch[$];
    bit      pat [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    int n_assert = 0;
    int n_fail   = 0;
    int cyc = 0, rd_total = 0, pop_total = 0, burst_reads = 0, burst_starts = 0;
    int model_last = NUM_CH - 1;
    int first_rd_cyc = -1, last_rd_cyc = -1, first_vld_cyc = -1;
    int ready_mode = 0, pat_i = 0;
    bit gap_expected = 0, vgap_check = 0, prev_eop_pop = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_upstream();
        logic [NUM_CH*LEVEL_W-1:0] lv;
        logic [NUM_CH*DATA_W-1:0]  dv;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            int sz = fq[i].size();
            lv[i*LEVEL_W +: LEVEL_W] = (sz > 255) ? 8'hFF : LEVEL_W'(sz);
            dv[i*DATA_W +: DATA_W]   = $urandom();
        end
        if (rd_pipe[RD_LATENCY].vld) begin
            dv[rd_pipe[RD_LATENCY].ch*DATA_W +: DATA_W] = rd_pipe[RD_LATENCY].data;
        end
        bus.ch_level   = lv;
        bus.ch_rd_data = dv;
    endtask

    task automatic tick();
        bit                r;
        logic [NUM_CH-1:0] rde;
        int                ch;
        exp_t              e;
        @(negedge clk);
        cyc++;
        for (int k = RD_LATENCY; k >= 1; k--) rd_pipe[k] = rd_pipe[k-1];
        rd_pipe[0].vld = 1'b0;
        if (rst_n) begin
            rde = bus.ch_rd_en;
            if (gap_expected) chk("burst_gap_rd_en", 64'(rde), 64'd0);
            gap_expected = 1'b0;
            if (rde != '0) begin
                chk("rd_en_onehot", 64'($onehot(rde)), 64'd1);
                chk("rd_without_credit", 64'((rd_total - pop_total) < int'(SKID_DEPTH)), 64'd1);
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                ch = 0;
                for (int i = 0; i < int'(NUM_CH); i++) if (rde[i]) ch = i;
                if (fq[ch].size() == 0) begin
                    chk("read_empty_fifo", 64'd1, 64'd0);
                end else begin
                    rd_pipe[0].vld  = 1'b1;
                    rd_pipe[0].ch   = ch;
                    rd_pipe[0].data = fq[ch].pop_front();
                end
                rd_total++;
                if (burst_reads == 0) burst_starts++;
                burst_reads++;
                if (burst_reads == int'(BURST_LEN)) begin
                    burst_reads  = 0;
                    gap_expected = 1'b1;
                end
            end
            case (ready_mode)
                0:       r = 1'b1;
                1:       begin r = pat[pat_i]; pat_i = (pat_i + 1) % 6; end
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            bus.avl_ready = r;
            if (vgap_check && prev_eop_pop) chk("pkt_gap_valid", 64'(bus.avl_valid), 64'd0);
            prev_eop_pop = 1'b0;
            if (bus.avl_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (bus.avl_valid && r) begin
                pop_total++;
                if (exp_q.size() == 0) begin
                    chk("extra_word", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", 64'(bus.avl_data), 64'(e.data));
                    chk("word_channel", 64'(bus.avl_channel), 64'(e.ch));
                    chk("word_sop", 64'(bus.avl_sop), 64'(e.sop));
                    chk("word_eop", 64'(bus.avl_eop), 64'(e.eop));
                end
                if (bus.avl_sop) pkt_ch.push_back(int'(bus.avl_channel));
                prev_eop_pop = bus.avl_eop;
            end
        end
        drive_upstream();
    endtask

    task automatic fill(input int ch, input int n);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom();
            fq[ch].push_back(w);
            mq[ch].push_back(w);
        end
        drive_upstream();
    endtask

    task automatic clear_all();
        for (int i = 0; i < int'(NUM_CH); i++) begin
            fq[i].delete();
            mq[i].delete();
        end
        drive_upstream();
    endtask

    // Packet-level round robin: next full channel above the previous grant gets the next burst.
    task automatic predict(input int max_pkts);
        bit done = 1'b0;
        for (int p = 0; p < max_pkts && !done; p++) begin
            int sel = -1;
            for (int k = 1; k <= int'(NUM_CH); k++) begin
                int c = (model_last + k) % int'(NUM_CH);
                if (sel < 0 && mq[c].size() >= int'(BURST_LEN)) sel = c;
            end
            if (sel < 0) begin
                done = 1'b1;
            end else begin
                model_last = sel;
                for (int w = 0; w < int'(BURST_LEN); w++) begin
                    exp_t e;
                    e.ch   = 3'(sel);
                    e.data = mq[sel].pop_front();
                    e.sop  = (w == 0);
                    e.eop  = (w == int'(BURST_LEN) - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int b = budget;
        while ((exp_q.size() != 0 || rd_total != pop_total) && b > 0) begin
            tick();
            b--;
        end
        chk("drain_words_left", 64'(exp_q.size()), 64'd0);
        repeat (20) tick();
        chk("drain_outstanding", 64'(rd_total - pop_total), 64'd0);
    endtask

    task automatic begin_test();
        pkt_ch.delete();
        first_rd_cyc  = -1;
        last_rd_cyc   = -1;
        first_vld_cyc = -1;
    endtask

    task automatic wait_burst_word(input int n, input string tag);
        int b = 200;
        while (burst_reads != n && b > 0) begin
            tick();
            b--;
        end
        chk(tag, 64'(burst_reads), 64'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cs, r0, s, b;
        int order [4] = '{0, 1, 3, 0};
        bus.avl_ready = 1'b1;
        for (int k = 0; k <= int'(RD_LATENCY); k++) rd_pipe[k].vld = 1'b0;
        drive_upstream();
        repeat (3) tick();
        chk("rst_rd_en", 64'(bus.ch_rd_en), 64'd0);
        chk("rst_valid", 64'(bus.avl_valid), 64'd0);
        chk("rst_sop", 64'(bus.avl_sop), 64'd0);
        chk("rst_eop", 64'(bus.avl_eop), 64'd0);
        chk("rst_data", 64'(bus.avl_data), 64'd0);
        chk("rst_channel", 64'(bus.avl_channel), 64'd0);
        rst_n = 1'b1;
        tick();

        // Three full channels: round-robin order from reset, four packets only.
        begin_test();
        fill(0, 64); fill(1, 64); fill(3, 64);
        enable = 1'b1;
        predict(4);
        vgap_check = 1'b1;
        s = burst_starts;
        b = 2000;
        while (burst_starts < s + 4 && b > 0) begin tick(); b--; end
        enable = 1'b0;
        chk("t2_burst_count", 64'(burst_starts - s), 64'd4);
        drain(400);
        vgap_check = 1'b0;
        chk("t2_pkt_count", 64'(pkt_ch.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_pkt_order", 64'((pkt_ch.size() > i) ? pkt_ch[i] : -1), 64'(order[i]));
        end
        clear_all();

        // Single burst on channel 2: exact latencies and back-to-back reads.
        begin_test();
        fill(2, 16);
        cs = cyc;
        r0 = rd_total;
        enable = 1'b1;
        predict(100);
        drain(200);
        enable = 1'b0;
        chk("t1_first_rd", 64'(first_rd_cyc - cs), 64'd1);
        chk("t1_rd_span", 64'(last_rd_cyc - first_rd_cyc), 64'(BURST_LEN - 1));
        chk("t1_rd_count", 64'(rd_total - r0), 64'(BURST_LEN));
        chk("t1_first_valid", 64'(first_vld_cyc - cs), 64'(2 + RD_LATENCY));
        chk("t1_channel", 64'((pkt_ch.size() > 0) ? pkt_ch[0] : -1), 64'd2);

        // One word short of a burst, then topped up.
        begin_test();
        fill(1, 15);
        enable = 1'b1;
        r0 = rd_total;
        repeat (20) tick();
        chk("t3_no_grant", 64'(rd_total - r0), 64'd0);
        fill(1, 1);
        cs = cyc;
        predict(100);
        drain(200);
        chk("t3_start_latency", 64'(first_rd_cyc >= 0 && (first_rd_cyc - cs) <= 2), 64'd1);
        enable = 1'b0;

        // Periodic backpressure 1,0,0,0,0,1.
        begin_test();
        ready_mode = 1;
        pat_i = 0;
        fill(3, 32);
        enable = 1'b1;
        predict(100);
        drain(2000);
        enable = 1'b0;
        ready_mode = 0;

        // Enable dropped mid-burst: burst completes, nothing further.
        begin_test();
        fill(0, 32); fill(1, 16);
        r0 = rd_total;
        enable = 1'b1;
        predict(1);
        wait_burst_word(5, "t5_reach_word5");
        enable = 1'b0;
        drain(300);
        chk("t5_reads", 64'(rd_total - r0), 64'(BURST_LEN));
        repeat (30) tick();
        chk("t5_no_regrant", 64'(rd_total - r0), 64'(BURST_LEN));
        clear_all();

        // Asynchronous reset in the middle of a burst.
        begin_test();
        fill(3, 32);
        enable = 1'b1;
        predict(100);
        wait_burst_word(8, "t6_reach_word8");
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_rd_en", 64'(bus.ch_rd_en), 64'd0);
        chk("t6_rst_valid", 64'(bus.avl_valid), 64'd0);
        chk("t6_rst_sop", 64'(bus.avl_sop), 64'd0);
        chk("t6_rst_eop", 64'(bus.avl_eop), 64'd0);
        chk("t6_rst_data", 64'(bus.avl_data), 64'd0);
        chk("t6_rst_channel", 64'(bus.avl_channel), 64'd0);
        enable = 1'b0;
        exp_q.delete();
        for (int k = 0; k <= int'(RD_LATENCY); k++) rd_pipe[k].vld = 1'b0;
        rd_total = 0; pop_total = 0; burst_reads = 0;
        gap_expected = 1'b0; prev_eop_pop = 1'b0;
        model_last = NUM_CH - 1;
        clear_all();
        repeat (2) tick();
        rst_n = 1'b1;
        begin_test();
        fill(0, 16); fill(2, 16);
        enable = 1'b1;
        predict(100);
        drain(300);
        enable = 1'b0;
        chk("t6_pkt_count", 64'(pkt_ch.size()), 64'd2);
        chk("t6_first_channel", 64'((pkt_ch.size() > 0) ? pkt_ch[0] : -1), 64'd0);

        // Random fill levels with random backpressure.
        for (int round = 0; round < 3; round++) begin
            clear_all();
            begin_test();
            for (int c = 0; c < int'(NUM_CH); c++) fill(c, int'($urandom_range(0, 50)));
            ready_mode = 2;
            enable = 1'b1;
            predict(100);
            drain(3000);
            enable = 1'b0;
            ready_mode = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
